// File: rtl/cv32e40p_data_arb_pkg.sv
// ----------------------------------------------------------------------------
// cv32e40p_data_arb_pkg
// Shared types for the OBI data arbiter:
//   arb_id_e   - identifies which upstream port owns a transaction
//   obi_req_t  - request payload (addr/we/be/wdata) at the core's native
//                32-bit data-bus width
//   arb_other  - returns the opposite port id (used by round-robin selection)
// ----------------------------------------------------------------------------
package cv32e40p_data_arb_pkg;

  typedef enum logic {
    ARB_P0 = 1'b0,
    ARB_P1 = 1'b1
  } arb_id_e;

  localparam int unsigned OBI_ADDR_W = 32;
  localparam int unsigned OBI_DATA_W = 32;

  typedef struct packed {
    logic [OBI_ADDR_W-1:0]   addr;
    logic                    we;
    logic [OBI_DATA_W/8-1:0] be;
    logic [OBI_DATA_W-1:0]   wdata;
  } obi_req_t;

  function automatic arb_id_e arb_other(input arb_id_e id);
    arb_id_e r;
    if (id == ARB_P0) begin
      r = ARB_P1;
    end else begin
      r = ARB_P0;
    end
    return r;
  endfunction

endpackage

// File: rtl/cv32e40p_data_arb_id_fifo.sv
// ----------------------------------------------------------------------------
// cv32e40p_data_arb_id_fifo
// In-order record of which port issued each outstanding transaction.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   push_i         record push_id_i (ignored while full)
//   push_id_i      port id of the transaction just handshaked
//   pop_i          retire the head entry (ignored while empty)
//   head_o         port id owning the oldest outstanding transaction
//   full_o         DEPTH entries held
//   empty_o        nothing outstanding
// Simultaneous push and pop are supported; pointers wrap modulo DEPTH so
// non-power-of-two depths work.
// ----------------------------------------------------------------------------
module cv32e40p_data_arb_id_fifo
  import cv32e40p_data_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    push_i,
  input  arb_id_e push_id_i,
  input  logic    pop_i,
  output arb_id_e head_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  arb_id_e mem_q [DEPTH];
  ptr_t    wr_ptr_q, wr_ptr_d;
  ptr_t    rd_ptr_q, rd_ptr_d;
  cnt_t    cnt_q, cnt_d;
  logic    do_push_s;
  logic    do_pop_s;

  function automatic ptr_t ptr_inc(input ptr_t p);
    ptr_t r;
    if (p == ptr_t'(DEPTH - 1)) begin
      r = ptr_t'(0);
    end else begin
      r = p + ptr_t'(1);
    end
    return r;
  endfunction

  assign full_o    = (cnt_q == cnt_t'(DEPTH));
  assign empty_o   = (cnt_q == cnt_t'(0));
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;
  assign head_o    = mem_q[rd_ptr_q];

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push_s) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_d = cnt_q + cnt_t'(1);
      2'b01:   cnt_d = cnt_q - cnt_t'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage and pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= ptr_t'(0);
      rd_ptr_q <= ptr_t'(0);
      cnt_q    <= cnt_t'(0);
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= ARB_P0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= push_id_i;
      end
    end
  end

endmodule

// File: rtl/cv32e40p_obi_data_arbiter.sv
// ----------------------------------------------------------------------------
// cv32e40p_obi_data_arbiter
// Merges the core's two OBI data requesters (port 0 = 32-bit LSU, port 1 =
// secondary port) onto one downstream OBI bus and steers each response back
// to the port that issued it, relying on OBI in-order responses.
// Ports:
//   clk_i, rst_ni                     clock, asynchronous active-low reset
//   pN_req_i / pN_gnt_o               upstream request/grant, N = 0,1
//   pN_addr_i/we_i/be_i/wdata_i       upstream request payload
//   pN_rvalid_o / pN_rdata_o          upstream response (rdata = m_rdata_i)
//   m_req_o / m_gnt_i                 downstream request/grant
//   m_addr_o/we_o/be_o/wdata_o        downstream payload (winner mux)
//   m_rvalid_i / m_rdata_i            downstream response
//   busy_o                            any transaction outstanding
// Build options:
//   CV32E40P_DATA_ARB_RR_EN  round-robin on contention (default: port 0 wins)
//   CV32E40P_ASSERT_ON       attaches cv32e40p_data_arb_checker
// ----------------------------------------------------------------------------

`ifdef CV32E40P_ASSERT_ON
// Protocol checks kept apart from the datapath.
module cv32e40p_data_arb_checker (
  input logic clk_i,
  input logic rst_ni,
  input logic m_req_i,
  input logic m_gnt_i,
  input logic m_rvalid_i,
  input logic fifo_empty_i
);

  a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(m_rvalid_i && fifo_empty_i))
    else $error("cv32e40p_obi_data_arbiter: m_rvalid_i with no outstanding transaction");

  a_req_held_until_gnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (m_req_i && !m_gnt_i) |=> m_req_i)
    else $error("cv32e40p_obi_data_arbiter: m_req_o withdrawn before grant");

endmodule
`endif

module cv32e40p_obi_data_arbiter
  import cv32e40p_data_arb_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,

  input  logic                p0_req_i,
  output logic                p0_gnt_o,
  input  logic [ADDR_W-1:0]   p0_addr_i,
  input  logic                p0_we_i,
  input  logic [DATA_W/8-1:0] p0_be_i,
  input  logic [DATA_W-1:0]   p0_wdata_i,
  output logic                p0_rvalid_o,
  output logic [DATA_W-1:0]   p0_rdata_o,

  input  logic                p1_req_i,
  output logic                p1_gnt_o,
  input  logic [ADDR_W-1:0]   p1_addr_i,
  input  logic                p1_we_i,
  input  logic [DATA_W/8-1:0] p1_be_i,
  input  logic [DATA_W-1:0]   p1_wdata_i,
  output logic                p1_rvalid_o,
  output logic [DATA_W-1:0]   p1_rdata_o,

  output logic                m_req_o,
  input  logic                m_gnt_i,
  output logic [ADDR_W-1:0]   m_addr_o,
  output logic                m_we_o,
  output logic [DATA_W/8-1:0] m_be_o,
  output logic [DATA_W-1:0]   m_wdata_o,
  input  logic                m_rvalid_i,
  input  logic [DATA_W-1:0]   m_rdata_i,

  output logic                busy_o
);

  // Same field layout as obi_req_t, sized by this instance's parameters.
  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic                we;
    logic [DATA_W/8-1:0] be;
    logic [DATA_W-1:0]   wdata;
  } req_t;

  req_t    p0_s, p1_s, win_s;
  arb_id_e winner_s;
  logic    win_req_s;
  logic    hs_s;
  logic    resp_s;

  logic    lock_q, lock_d;
  arb_id_e locked_id_q, locked_id_d;
`ifdef CV32E40P_DATA_ARB_RR_EN
  arb_id_e last_id_q, last_id_d;
`endif

  arb_id_e fifo_head_s;
  logic    fifo_full_s;
  logic    fifo_empty_s;

  assign p0_s.addr  = p0_addr_i;
  assign p0_s.we    = p0_we_i;
  assign p0_s.be    = p0_be_i;
  assign p0_s.wdata = p0_wdata_i;
  assign p1_s.addr  = p1_addr_i;
  assign p1_s.we    = p1_we_i;
  assign p1_s.be    = p1_be_i;
  assign p1_s.wdata = p1_wdata_i;

  // Winner selection; a pending ungranted request freezes the choice.
  always_comb begin
    winner_s = ARB_P0;
    if (lock_q) begin
      winner_s = locked_id_q;
    end else if (p0_req_i && p1_req_i) begin
`ifdef CV32E40P_DATA_ARB_RR_EN
      winner_s = arb_other(last_id_q);
`else
      winner_s = ARB_P0;
`endif
    end else if (p1_req_i) begin
      winner_s = ARB_P1;
    end else begin
      winner_s = ARB_P0;
    end
  end

  assign win_s     = (winner_s == ARB_P1) ? p1_s : p0_s;
  assign win_req_s = (winner_s == ARB_P1) ? p1_req_i : p0_req_i;

  // Issue stalls while the ID FIFO is full, with no bypass from a same-cycle
  // response: the FIFO only frees a slot at the next edge.
  assign m_req_o   = win_req_s & ~fifo_full_s;
  assign hs_s      = m_req_o & m_gnt_i;
  assign m_addr_o  = win_s.addr;
  assign m_we_o    = win_s.we;
  assign m_be_o    = win_s.be;
  assign m_wdata_o = win_s.wdata;
  assign p0_gnt_o  = hs_s & (winner_s == ARB_P0);
  assign p1_gnt_o  = hs_s & (winner_s == ARB_P1);

  // Responses with nothing outstanding (e.g. after a reset) are dropped.
  assign resp_s      = m_rvalid_i & ~fifo_empty_s;
  assign p0_rvalid_o = resp_s & (fifo_head_s == ARB_P0);
  assign p1_rvalid_o = resp_s & (fifo_head_s == ARB_P1);
  assign p0_rdata_o  = m_rdata_i;
  assign p1_rdata_o  = m_rdata_i;
  assign busy_o      = ~fifo_empty_s;

  // Lock tracking: hold the current winner until its request is granted.
  always_comb begin
    lock_d      = lock_q;
    locked_id_d = locked_id_q;
    if (m_req_o && !m_gnt_i) begin
      lock_d      = 1'b1;
      locked_id_d = winner_s;
    end else if (hs_s) begin
      lock_d      = 1'b0;
      locked_id_d = locked_id_q;
    end else begin
      lock_d      = lock_q;
      locked_id_d = locked_id_q;
    end
  end

`ifdef CV32E40P_DATA_ARB_RR_EN
  // Remember the last granted port so contention alternates.
  always_comb begin
    last_id_d = last_id_q;
    if (hs_s) begin
      last_id_d = winner_s;
    end else begin
      last_id_d = last_id_q;
    end
  end

  // Round-robin history register; resets to port 1 so port 0 wins first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_id_q <= ARB_P1;
    end else begin
      last_id_q <= last_id_d;
    end
  end
`endif

  // Lock state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q      <= 1'b0;
      locked_id_q <= ARB_P0;
    end else begin
      lock_q      <= lock_d;
      locked_id_q <= locked_id_d;
    end
  end

  cv32e40p_data_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (hs_s),
    .push_id_i (winner_s),
    .pop_i     (resp_s),
    .head_o    (fifo_head_s),
    .full_o    (fifo_full_s),
    .empty_o   (fifo_empty_s)
  );

`ifdef CV32E40P_ASSERT_ON
  cv32e40p_data_arb_checker u_checker (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .m_req_i      (m_req_o),
    .m_gnt_i      (m_gnt_i),
    .m_rvalid_i   (m_rvalid_i),
    .fifo_empty_i (fifo_empty_s)
  );
`endif

endmodule

// File: tb/tb_cv32e40p_obi_data_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cv32e40p_obi_data_arbiter
// Scenario tasks drive the arbiter cycle by cycle. When a grant is expected
// the owning port id is queued; when the bench returns a downstream response
// the head of the queue says which port must see rvalid.
// Inputs change 1 time unit after the rising edge; outputs are sampled 3
// units later, well before the next edge.
// ----------------------------------------------------------------------------
module tb_cv32e40p_obi_data_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        p0_req_i, p0_gnt_o, p0_we_i, p0_rvalid_o;
  logic [31:0] p0_addr_i, p0_wdata_i, p0_rdata_o;
  logic [3:0]  p0_be_i;
  logic        p1_req_i, p1_gnt_o, p1_we_i, p1_rvalid_o;
  logic [31:0] p1_addr_i, p1_wdata_i, p1_rdata_o;
  logic [3:0]  p1_be_i;
  logic        m_req_o, m_gnt_i, m_we_o, m_rvalid_i, busy_o;
  logic [31:0] m_addr_o, m_wdata_o, m_rdata_i;
  logic [3:0]  m_be_o;

  int   n_cmp = 0;
  int   n_err = 0;
  logic exp_q[$];   // expected response owner: 0 = port 0, 1 = port 1

  always #5 clk_i = ~clk_i;

  cv32e40p_obi_data_arbiter #(
    .MAX_OUTSTANDING (2),
    .ADDR_W          (32),
    .DATA_W          (32)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .p0_req_i    (p0_req_i),
    .p0_gnt_o    (p0_gnt_o),
    .p0_addr_i   (p0_addr_i),
    .p0_we_i     (p0_we_i),
    .p0_be_i     (p0_be_i),
    .p0_wdata_i  (p0_wdata_i),
    .p0_rvalid_o (p0_rvalid_o),
    .p0_rdata_o  (p0_rdata_o),
    .p1_req_i    (p1_req_i),
    .p1_gnt_o    (p1_gnt_o),
    .p1_addr_i   (p1_addr_i),
    .p1_we_i     (p1_we_i),
    .p1_be_i     (p1_be_i),
    .p1_wdata_i  (p1_wdata_i),
    .p1_rvalid_o (p1_rvalid_o),
    .p1_rdata_o  (p1_rdata_o),
    .m_req_o     (m_req_o),
    .m_gnt_i     (m_gnt_i),
    .m_addr_o    (m_addr_o),
    .m_we_o      (m_we_o),
    .m_be_o      (m_be_o),
    .m_wdata_o   (m_wdata_o),
    .m_rvalid_i  (m_rvalid_i),
    .m_rdata_i   (m_rdata_i),
    .busy_o      (busy_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    p0_req_i = 1'b0; p0_addr_i = 32'h0; p0_we_i = 1'b0; p0_be_i = 4'h0; p0_wdata_i = 32'h0;
    p1_req_i = 1'b0; p1_addr_i = 32'h0; p1_we_i = 1'b0; p1_be_i = 4'h0; p1_wdata_i = 32'h0;
    m_gnt_i = 1'b0; m_rvalid_i = 1'b0; m_rdata_i = 32'h0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_ni = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    step();
    idle_inputs();
    rst_ni = 1'b0;
    #3;
    n_cmp++;
    if ({m_req_o, p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o, busy_o} !== 6'b000000) begin
      n_err++;
      $display("FAIL reset_in: outputs=%b required=000000",
               {m_req_o, p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o, busy_o});
    end
    step();
    rst_ni = 1'b1;
    step();
    #3;
    n_cmp++;
    if ({m_req_o, p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o, busy_o} !== 6'b000000) begin
      n_err++;
      $display("FAIL reset_out: outputs=%b required=000000",
               {m_req_o, p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o, busy_o});
    end
    step();
  endtask

  task automatic test_single_read();
    logic e;
    apply_reset();
    p0_req_i = 1'b1; p0_addr_i = 32'h0000_1000; p0_be_i = 4'hF; m_gnt_i = 1'b1;
    exp_q.push_back(1'b0);
    #3;
    n_cmp++;
    if ({m_req_o, p0_gnt_o, p1_gnt_o} !== 3'b110) begin
      n_err++; $display("FAIL single_gnt: req/g0/g1=%b required=110", {m_req_o, p0_gnt_o, p1_gnt_o});
    end
    n_cmp++;
    if (m_addr_o !== 32'h0000_1000 || m_we_o !== 1'b0) begin
      n_err++; $display("FAIL single_addr: addr=%h we=%b required 00001000/0", m_addr_o, m_we_o);
    end
    step();
    p0_req_i = 1'b0; m_gnt_i = 1'b0;
    #3;
    n_cmp++;
    if ({m_req_o, busy_o, p0_rvalid_o, p1_rvalid_o} !== 4'b0100) begin
      n_err++; $display("FAIL single_wait: req/busy/rv0/rv1=%b required=0100",
                        {m_req_o, busy_o, p0_rvalid_o, p1_rvalid_o});
    end
    step();
    m_rvalid_i = 1'b1; m_rdata_i = 32'hDEAD_BEEF;
    #3;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++; $display("FAIL single_resp: response with empty scoreboard");
    end else begin
      e = exp_q.pop_front();
      if ({p1_rvalid_o, p0_rvalid_o} !== (e ? 2'b10 : 2'b01)) begin
        n_err++; $display("FAIL single_resp: rv1/rv0=%b required=%b", {p1_rvalid_o, p0_rvalid_o},
                          (e ? 2'b10 : 2'b01));
      end
    end
    n_cmp++;
    if (p0_rdata_o !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL single_rdata: rdata=%h required=deadbeef", p0_rdata_o);
    end
    step();
    m_rvalid_i = 1'b0;
    #3;
    n_cmp++;
    if ({busy_o, p0_rvalid_o} !== 2'b00) begin
      n_err++; $display("FAIL single_idle: busy/rv0=%b required=00", {busy_o, p0_rvalid_o});
    end
    step();
  endtask

  task automatic test_lock();
    logic e;
    apply_reset();
    p0_req_i = 1'b1; p0_addr_i = 32'hA000_0000;
    p1_req_i = 1'b1; p1_addr_i = 32'hB000_0000;
    for (int c = 0; c < 4; c++) begin
      m_gnt_i = (c == 3);
      if (c == 3) exp_q.push_back(1'b0);
      #3;
      n_cmp++;
      if (m_addr_o !== 32'hA000_0000) begin
        n_err++; $display("FAIL lock_addr c%0d: addr=%h required=a0000000", c, m_addr_o);
      end
      n_cmp++;
      if ({m_req_o, p0_gnt_o, p1_gnt_o} !== {1'b1, (c == 3), 1'b0}) begin
        n_err++; $display("FAIL lock_gnt c%0d: req/g0/g1=%b required=%b", c,
                          {m_req_o, p0_gnt_o, p1_gnt_o}, {1'b1, (c == 3), 1'b0});
      end
      step();
    end
    p0_req_i = 1'b0;
    exp_q.push_back(1'b1);
    #3;
    n_cmp++;
    if ({p0_gnt_o, p1_gnt_o} !== 2'b01 || m_addr_o !== 32'hB000_0000) begin
      n_err++; $display("FAIL lock_p1: g0/g1=%b addr=%h required 01/b0000000",
                        {p0_gnt_o, p1_gnt_o}, m_addr_o);
    end
    step();
    p1_req_i = 1'b0; m_gnt_i = 1'b0;
    for (int r = 0; r < 2; r++) begin
      m_rvalid_i = 1'b1; m_rdata_i = 32'h5500_0000 + 32'(r);
      #3;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++; $display("FAIL lock_resp %0d: response with empty scoreboard", r);
      end else begin
        e = exp_q.pop_front();
        if ({p1_rvalid_o, p0_rvalid_o} !== (e ? 2'b10 : 2'b01)) begin
          n_err++; $display("FAIL lock_resp %0d: rv1/rv0=%b required=%b", r,
                            {p1_rvalid_o, p0_rvalid_o}, (e ? 2'b10 : 2'b01));
        end
      end
      step();
    end
    m_rvalid_i = 1'b0;
  endtask

  task automatic test_contention();
    logic e;
    logic g;
    apply_reset();
    p0_addr_i = 32'h0000_00C0; p1_addr_i = 32'h0000_00C4; m_gnt_i = 1'b1;
    for (int k = 0; k < 7; k++) begin
      p0_req_i = (k < 6); p1_req_i = (k < 6);
      m_rvalid_i = (k >= 1); m_rdata_i = 32'hC000_0000 + 32'(k);
`ifdef CV32E40P_DATA_ARB_RR_EN
      g = (k % 2 == 1);
`else
      g = 1'b0;
`endif
      if (k < 6) exp_q.push_back(g);
      #3;
      if (k < 6) begin
        n_cmp++;
        if ({p1_gnt_o, p0_gnt_o} !== (g ? 2'b10 : 2'b01)) begin
          n_err++; $display("FAIL contend_gnt k%0d: g1/g0=%b required=%b", k,
                            {p1_gnt_o, p0_gnt_o}, (g ? 2'b10 : 2'b01));
        end
      end
      if (k >= 1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL contend_resp k%0d: response with empty scoreboard", k);
        end else begin
          e = exp_q.pop_front();
          if ({p1_rvalid_o, p0_rvalid_o} !== (e ? 2'b10 : 2'b01)) begin
            n_err++; $display("FAIL contend_resp k%0d: rv1/rv0=%b required=%b", k,
                              {p1_rvalid_o, p0_rvalid_o}, (e ? 2'b10 : 2'b01));
          end
        end
      end
      step();
    end
    m_rvalid_i = 1'b0; m_gnt_i = 1'b0;
    #3;
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_err++; $display("FAIL contend_end: busy=%b required=0", busy_o);
    end
    step();
  endtask

  task automatic test_outstanding();
    logic e;
    logic er;
    apply_reset();
    p0_req_i = 1'b1; p0_addr_i = 32'h0000_2000; m_gnt_i = 1'b1; m_rdata_i = 32'h0BAD_F00D;
    for (int t = 0; t < 7; t++) begin
      m_rvalid_i = (t == 5);
      er = (t < 2) || (t == 6);
      if (er) exp_q.push_back(1'b0);
      #3;
      n_cmp++;
      if ({m_req_o, p0_gnt_o, busy_o} !== {er, er, (t > 0)}) begin
        n_err++; $display("FAIL outst t%0d: req/g0/busy=%b required=%b", t,
                          {m_req_o, p0_gnt_o, busy_o}, {er, er, (t > 0)});
      end
      if (t == 5) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL outst_resp: response with empty scoreboard");
        end else begin
          e = exp_q.pop_front();
          if ({p1_rvalid_o, p0_rvalid_o} !== (e ? 2'b10 : 2'b01)) begin
            n_err++; $display("FAIL outst_resp: rv1/rv0=%b required=%b",
                              {p1_rvalid_o, p0_rvalid_o}, (e ? 2'b10 : 2'b01));
          end
        end
      end
      step();
    end
    p0_req_i = 1'b0; m_gnt_i = 1'b0;
    for (int r = 0; r < 2; r++) begin
      m_rvalid_i = 1'b1;
      #3;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++; $display("FAIL outst_drain %0d: response with empty scoreboard", r);
      end else begin
        e = exp_q.pop_front();
        if ({p1_rvalid_o, p0_rvalid_o} !== (e ? 2'b10 : 2'b01)) begin
          n_err++; $display("FAIL outst_drain %0d: rv1/rv0=%b required=%b", r,
                            {p1_rvalid_o, p0_rvalid_o}, (e ? 2'b10 : 2'b01));
        end
      end
      step();
    end
    m_rvalid_i = 1'b0;
  endtask

  task automatic test_in_order();
    logic e;
    apply_reset();
    m_gnt_i = 1'b1;
    // t0: port 0 write
    p0_req_i = 1'b1; p0_we_i = 1'b1; p0_be_i = 4'h3; p0_addr_i = 32'h0000_3000;
    p0_wdata_i = 32'h1234_5678;
    exp_q.push_back(1'b0);
    #3;
    n_cmp++;
    if ({p0_gnt_o, m_we_o, m_be_o, m_wdata_o} !== {1'b1, 1'b1, 4'h3, 32'h1234_5678}) begin
      n_err++; $display("FAIL order_wr: g0=%b we=%b be=%h wdata=%h required 1/1/3/12345678",
                        p0_gnt_o, m_we_o, m_be_o, m_wdata_o);
    end
    step();
    // t1: port 1 read
    p0_req_i = 1'b0; p1_req_i = 1'b1; p1_we_i = 1'b0; p1_addr_i = 32'h0000_4000;
    exp_q.push_back(1'b1);
    #3;
    n_cmp++;
    if ({p1_gnt_o, m_we_o} !== 2'b10 || m_addr_o !== 32'h0000_4000) begin
      n_err++; $display("FAIL order_rd1: g1/we=%b addr=%h required 10/00004000",
                        {p1_gnt_o, m_we_o}, m_addr_o);
    end
    step();
    // t2..t4: port 0 read waits for a free slot, responses come back in order
    p1_req_i = 1'b0; p0_req_i = 1'b1; p0_we_i = 1'b0; p0_addr_i = 32'h0000_3004;
    for (int t = 2; t < 5; t++) begin
      m_rvalid_i = 1'b1; m_rdata_i = 32'hE000_0000 + 32'(t);
      if (t == 4) p0_req_i = 1'b0;
      if (t == 3) exp_q.push_back(1'b0);
      #3;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++; $display("FAIL order_resp t%0d: response with empty scoreboard", t);
      end else begin
        e = exp_q.pop_front();
        if ({p1_rvalid_o, p0_rvalid_o} !== (e ? 2'b10 : 2'b01)) begin
          n_err++; $display("FAIL order_resp t%0d: rv1/rv0=%b required=%b", t,
                            {p1_rvalid_o, p0_rvalid_o}, (e ? 2'b10 : 2'b01));
        end
      end
      n_cmp++;
      if (p0_gnt_o !== (t == 3)) begin
        n_err++; $display("FAIL order_gnt t%0d: g0=%b required=%b", t, p0_gnt_o, (t == 3));
      end
      step();
    end
    m_rvalid_i = 1'b0; m_gnt_i = 1'b0;
    #3;
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_err++; $display("FAIL order_end: busy=%b required=0", busy_o);
    end
    step();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    p0_req_i = 1'b1; p0_addr_i = 32'h0000_5000; m_gnt_i = 1'b1;
    step();
    step();
    p0_req_i = 1'b0; m_gnt_i = 1'b0;
    #3;
    n_cmp++;
    if ({busy_o, m_req_o} !== 2'b10) begin
      n_err++; $display("FAIL rstmid_busy: busy/req=%b required=10", {busy_o, m_req_o});
    end
    step();
    rst_ni = 1'b0;
    #3;
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_err++; $display("FAIL rstmid_clear: busy=%b required=0", busy_o);
    end
    step();
    rst_ni = 1'b1;
    step();
    m_rvalid_i = 1'b1; m_rdata_i = 32'h7777_7777;
    #3;
    n_cmp++;
    if ({p0_rvalid_o, p1_rvalid_o, busy_o} !== 3'b000) begin
      n_err++; $display("FAIL rstmid_drop: rv0/rv1/busy=%b required=000",
                        {p0_rvalid_o, p1_rvalid_o, busy_o});
    end
    step();
    m_rvalid_i = 1'b0;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_lock();
    test_contention();
    test_outstanding();
    test_in_order();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within 100000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
